// File: rtl/banco_registradores_pkg.sv
// Width constants and types shared by the register file and the ALU.
// No logic: types, constants and one elaboration-time helper.
// Backpressure: not applicable.
package pacote_processador;

    localparam int LARGURA_DADO = 8;
    localparam int NUM_REGS     = 8;
    localparam int END_W        = 3;

    typedef logic [END_W-1:0]        end_reg_t;
    typedef logic [LARGURA_DADO-1:0] palavra_t;

    function automatic bit eh_pot2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/banco_registradores_latch_operandos.sv
// Operand latch feeding the ALU; priority reset > descartar > segurar > load.
// Latency: 1 cycle from the read data to operando1/2 and dado_valido.
// Backpressure: segurar holds the operands and valid; descartar inserts a bubble.
module latch_operandos
    import pacote_processador::*;
#(
    parameter int LARGURA = pacote_processador::LARGURA_DADO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               segurar,
    input  logic               descartar,
    input  logic               le_valido,
    input  logic [LARGURA-1:0] leitura1,
    input  logic [LARGURA-1:0] leitura2,
    output logic [LARGURA-1:0] operando1,
    output logic [LARGURA-1:0] operando2,
    output logic               dado_valido
);

    logic [LARGURA-1:0] operando1_d, operando1_q;
    logic [LARGURA-1:0] operando2_d, operando2_q;
    logic               valido_d, valido_q;

    always_comb begin
        operando1_d = operando1_q;
        operando2_d = operando2_q;
        valido_d    = valido_q;
        if (descartar) begin
            operando1_d = '0;
            operando2_d = '0;
            valido_d    = 1'b0;
        end else if (!segurar) begin
            // Operands load even without a valid request; only the flag tracks le_valido.
            operando1_d = leitura1;
            operando2_d = leitura2;
            valido_d    = le_valido;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            operando1_q <= '0;
            operando2_q <= '0;
            valido_q    <= 1'b0;
        end else begin
            operando1_q <= operando1_d;
            operando2_q <= operando2_d;
            valido_q    <= valido_d;
        end
    end

    assign operando1   = operando1_q;
    assign operando2   = operando2_q;
    assign dado_valido = valido_q;

endmodule

// File: rtl/banco_registradores.sv
// Register file with write-first bypass and a registered operand pair for the ALU.
// Latency: 1 cycle; segurar stalls and descartar flushes the latch. BANCO_R0_ZERO_EN: r0 reads as zero.
// Backpressure: writes always proceed; only the operand latch honours segurar/descartar.
module banco_registradores
    import pacote_processador::*;
#(
    parameter int LARGURA  = pacote_processador::LARGURA_DADO,
    parameter int NUM_REGS = pacote_processador::NUM_REGS,
    parameter int END_W    = pacote_processador::END_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               le_valido,
    input  logic [END_W-1:0]   end_leitura1,
    input  logic [END_W-1:0]   end_leitura2,
    input  logic               escreve,
    input  logic [END_W-1:0]   end_escrita,
    input  logic [LARGURA-1:0] dado_escrita,
    input  logic               segurar,
    input  logic               descartar,
    output logic [LARGURA-1:0] operando1,
    output logic [LARGURA-1:0] operando2,
    output logic               dado_valido
);

    if (NUM_REGS < 2 || !eh_pot2(NUM_REGS) || END_W != $clog2(NUM_REGS)) begin : g_param_invalido
        $error("banco_registradores: NUM_REGS must be a power of two >= 2 and END_W = log2(NUM_REGS)");
    end

    logic [LARGURA-1:0] regs_q [NUM_REGS];
    logic [LARGURA-1:0] regs_d [NUM_REGS];
    logic               escrita_ok;
    logic [LARGURA-1:0] leitura1, leitura2;

`ifdef BANCO_R0_ZERO_EN
    // r0 never takes a write, so it stays at its reset value of zero and never forwards.
    assign escrita_ok = escreve && (end_escrita != '0);
`else
    assign escrita_ok = escreve;
`endif

    always_comb begin
        regs_d = regs_q;
        if (escrita_ok) begin
            regs_d[end_escrita] = dado_escrita;
        end
    end

    always_comb begin
        leitura1 = regs_q[end_leitura1];
        leitura2 = regs_q[end_leitura2];
        if (escrita_ok && end_escrita == end_leitura1) begin
            leitura1 = dado_escrita;
        end
        if (escrita_ok && end_escrita == end_leitura2) begin
            leitura2 = dado_escrita;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    latch_operandos #(
        .LARGURA(LARGURA)
    ) u_latch (
        .clock      (clock),
        .reset      (reset),
        .segurar    (segurar),
        .descartar  (descartar),
        .le_valido  (le_valido),
        .leitura1   (leitura1),
        .leitura2   (leitura2),
        .operando1  (operando1),
        .operando2  (operando2),
        .dado_valido(dado_valido)
    );

endmodule
